// File: rtl/dadda_pkg.sv
// Shared definitions for the 4x4 Dadda multiplier and its downstream stages.
//   MUL_OP_W / MUL_PROD_W : multiplier operand width and product width (2x operand)
//   acc_state_e          : product accumulator FSM states
//   sat_add32            : generic saturating unsigned add for fixed-width users (<= 32 bits)
package dadda_pkg;

  localparam int unsigned MUL_OP_W   = 4;
  localparam int unsigned MUL_PROD_W = 2 * MUL_OP_W;

  typedef enum logic {
    StAccum = 1'b0,
    StFull  = 1'b1
  } acc_state_e;

  // Returns {overflow, sum} where sum is clamped to 2^width-1. Operands must already fit
  // in 'width' bits; width in 1..32.
  function automatic logic [32:0] sat_add32(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned width);
    logic [32:0] sum;
    logic [32:0] max;
    sum = {1'b0, a} + {1'b0, b};
    max = (33'd1 << width) - 33'd1;
    if (sum > max) begin
      sat_add32 = {1'b1, max[31:0]};
    end else begin
      sat_add32 = {1'b0, sum[31:0]};
    end
  endfunction

endpackage

// File: rtl/dadda_product_accumulator_sat_adder.sv
// Unsigned saturating adder: o_sum = min(i_a + zero_ext(i_b), 2^ACC_W-1).
//   i_a   [ACC_W]  running accumulator
//   i_b   [PROD_W] product to add (zero-extended)
//   o_sum [ACC_W]  clamped sum
//   o_ovf          high when the true sum did not fit and was clamped
module dadda_product_accumulator_sat_adder #(
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned PROD_W = 8
) (
  input  logic [ACC_W-1:0]  i_a,
  input  logic [PROD_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  localparam int unsigned SUM_W = ACC_W + 1;

  logic [SUM_W-1:0] w_full;

  // PROD_W <= ACC_W, so a carry out of bit ACC_W-1 is exactly the overflow condition.
  assign w_full = {1'b0, i_a} + SUM_W'(i_b);
  assign o_ovf  = w_full[ACC_W];
  assign o_sum  = w_full[ACC_W] ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule

// File: rtl/dadda_product_accumulator.sv
// Streaming accumulator behind the 4x4 Dadda multiplier. Sums up to COUNT unsigned products
// (fewer when a beat carries i_in_last) into one saturated ACC_W-bit result per frame.
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_clr                 synchronous abort of the partial frame (pending result untouched)
//   i_in_valid/o_in_ready product beat handshake; i_in_data product, i_in_last early frame end
//   o_out_valid/i_out_ready result handshake
//   o_out_data            saturated frame sum
//   o_out_beats           products in the frame (1..COUNT)
//   o_out_ovf             frame sum saturated
module dadda_product_accumulator
  import dadda_pkg::*;
#(
  parameter int unsigned PROD_W = MUL_PROD_W,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned COUNT  = 4,
  localparam int unsigned CNT_W = $clog2(COUNT + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [PROD_W-1:0] i_in_data,
  input  logic              i_in_last,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_out_data,
  output logic [CNT_W-1:0]  o_out_beats,
  output logic              o_out_ovf
);

  if (ACC_W < PROD_W) begin : g_bad_acc_w
    $error("ACC_W must be >= PROD_W");
  end
  if (COUNT < 1) begin : g_bad_count
    $error("COUNT must be >= 1");
  end

  acc_state_e       r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf_acc, w_ovf_acc_nxt;
  logic [ACC_W-1:0] r_out_data, w_out_data_nxt;
  logic [CNT_W-1:0] r_out_beats, w_out_beats_nxt;
  logic             r_out_ovf, w_out_ovf_nxt;

  logic             w_in_ready;
  logic             w_beat;
  logic             w_final;
  logic             w_retire;
  logic [ACC_W-1:0] w_sum;
  logic             w_clip;
  logic             w_ovf_frame;
  logic [CNT_W-1:0] w_cnt_inc;

  dadda_product_accumulator_sat_adder #(
    .ACC_W (ACC_W),
    .PROD_W(PROD_W)
  ) u_sat_adder (
    .i_a  (r_acc),
    .i_b  (i_in_data),
    .o_sum(w_sum),
    .o_ovf(w_clip)
  );

  // Only a pending, unconsumed result stalls the input; a result retiring this cycle frees it.
  assign w_in_ready  = !((r_state == StFull) && !i_out_ready);
  assign w_beat      = i_in_valid && w_in_ready;
  assign w_final     = (r_cnt == CNT_W'(COUNT - 1)) || i_in_last;
  assign w_retire    = (r_state == StFull) && i_out_ready;
  assign w_ovf_frame = r_ovf_acc || w_clip;
  assign w_cnt_inc   = r_cnt + CNT_W'(1);

  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_cnt_nxt       = r_cnt;
    w_ovf_acc_nxt   = r_ovf_acc;
    w_out_data_nxt  = r_out_data;
    w_out_beats_nxt = r_out_beats;
    w_out_ovf_nxt   = r_out_ovf;

    if (w_retire) begin
      w_state_nxt = StAccum;
    end

    if (i_clr) begin
      // Abort wins over any beat (and its in_last) arriving this cycle.
      w_acc_nxt     = '0;
      w_cnt_nxt     = '0;
      w_ovf_acc_nxt = 1'b0;
    end else if (w_beat) begin
      if (w_final) begin
        w_out_data_nxt  = w_sum;
        w_out_beats_nxt = w_cnt_inc;
        w_out_ovf_nxt   = w_ovf_frame;
        w_acc_nxt       = '0;
        w_cnt_nxt       = '0;
        w_ovf_acc_nxt   = 1'b0;
        w_state_nxt     = StFull;
      end else begin
        w_acc_nxt     = w_sum;
        w_cnt_nxt     = w_cnt_inc;
        w_ovf_acc_nxt = w_ovf_frame;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StAccum;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_ovf_acc   <= 1'b0;
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ovf_acc   <= w_ovf_acc_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_beats <= w_out_beats_nxt;
      r_out_ovf   <= w_out_ovf_nxt;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = (r_state == StFull);
  assign o_out_data  = r_out_data;
  assign o_out_beats = r_out_beats;
  assign o_out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_dadda_product_accumulator.sv
// Directed bench for dadda_product_accumulator. Three instances share one stimulus stream:
// the default build (ACC_W=16, COUNT=4), a narrow ACC_W=9 build and a COUNT=1 build.
module tb_dadda_product_accumulator;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_ready;

  logic        a_in_ready, a_out_valid, a_out_ovf;
  logic [15:0] a_out_data;
  logic [2:0]  a_out_beats;

  logic        b_in_ready, b_out_valid, b_out_ovf;
  logic [8:0]  b_out_data;
  logic [2:0]  b_out_beats;

  logic        c_in_ready, c_out_valid, c_out_ovf;
  logic [15:0] c_out_data;
  logic [0:0]  c_out_beats;

  int n_assert;
  int n_fail;

  dadda_product_accumulator #(.PROD_W(8), .ACC_W(16), .COUNT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_clr(clr),
    .i_in_valid(in_valid), .o_in_ready(a_in_ready), .i_in_data(in_data), .i_in_last(in_last),
    .o_out_valid(a_out_valid), .i_out_ready(out_ready), .o_out_data(a_out_data),
    .o_out_beats(a_out_beats), .o_out_ovf(a_out_ovf)
  );

  dadda_product_accumulator #(.PROD_W(8), .ACC_W(9), .COUNT(4)) dut9 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr),
    .i_in_valid(in_valid), .o_in_ready(b_in_ready), .i_in_data(in_data), .i_in_last(in_last),
    .o_out_valid(b_out_valid), .i_out_ready(out_ready), .o_out_data(b_out_data),
    .o_out_beats(b_out_beats), .o_out_ovf(b_out_ovf)
  );

  dadda_product_accumulator #(.PROD_W(8), .ACC_W(16), .COUNT(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_clr(clr),
    .i_in_valid(in_valid), .o_in_ready(c_in_ready), .i_in_data(in_data), .i_in_last(in_last),
    .o_out_valid(c_out_valid), .i_out_ready(out_ready), .o_out_data(c_out_data),
    .o_out_beats(c_out_beats), .o_out_ovf(c_out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are checked on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat(input logic [7:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    @(negedge clk);
    check("rst_valid", 32'(a_out_valid), 32'd0);
    check("rst_data", 32'(a_out_data), 32'd0);
    check("rst_beats", 32'(a_out_beats), 32'd0);
    check("rst_ovf", 32'(a_out_ovf), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    rst = 1'b0;

    // 1: full frame of 225s
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    check("t1_no_early_valid", 32'(a_out_valid), 32'd0);
    beat(8'd225, 1'b0);
    check("t1_valid", 32'(a_out_valid), 32'd1);
    check("t1_data", 32'(a_out_data), 32'd900);
    check("t1_beats", 32'(a_out_beats), 32'd4);
    check("t1_ovf", 32'(a_out_ovf), 32'd0);
    step();
    check("t1_one_cycle", 32'(a_out_valid), 32'd0);

    // 2: early end on in_last, then a full frame back to back
    beat(8'd10, 1'b0);
    beat(8'd20, 1'b1);
    check("t2_valid", 32'(a_out_valid), 32'd1);
    check("t2_data", 32'(a_out_data), 32'd30);
    check("t2_beats", 32'(a_out_beats), 32'd2);
    beat(8'd1, 1'b0);
    check("t2_retired", 32'(a_out_valid), 32'd0);
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b0);
    beat(8'd4, 1'b0);
    check("t2_next_data", 32'(a_out_data), 32'd10);
    check("t2_next_beats", 32'(a_out_beats), 32'd4);
    step();
    // in_last coinciding with the count limit ends the frame once
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b1);
    check("t2_last_at_limit_data", 32'(a_out_data), 32'd4);
    check("t2_last_at_limit_beats", 32'(a_out_beats), 32'd4);
    step();
    check("t2_no_double", 32'(a_out_valid), 32'd0);

    // 3: saturation in a 9-bit accumulator, ovf clears on the next frame
    do_reset();
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    check("t3_sat_valid", 32'(b_out_valid), 32'd1);
    check("t3_sat_data", 32'(b_out_data), 32'd511);
    check("t3_sat_ovf", 32'(b_out_ovf), 32'd1);
    check("t3_sat_beats", 32'(b_out_beats), 32'd4);
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    check("t3_next_data", 32'(b_out_data), 32'd4);
    check("t3_next_ovf", 32'(b_out_ovf), 32'd0);
    step();

    // 4: backpressure
    do_reset();
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'd7;
    #1;
    check("t4_stall_ready", 32'(a_in_ready), 32'd0);
    step();
    step();
    check("t4_hold_valid", 32'(a_out_valid), 32'd1);
    check("t4_hold_data", 32'(a_out_data), 32'd900);
    check("t4_hold_ready", 32'(a_in_ready), 32'd0);
    out_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(a_in_ready), 32'd1);
    step();
    check("t4_retired", 32'(a_out_valid), 32'd0);
    step();
    step();
    step();
    in_valid = 1'b0;
    check("t4_next_valid", 32'(a_out_valid), 32'd1);
    check("t4_next_data", 32'(a_out_data), 32'd28);
    check("t4_next_beats", 32'(a_out_beats), 32'd4);
    step();

    // 5: clr drops the partial frame and the beat in its cycle; pending result survives clr
    do_reset();
    beat(8'd50, 1'b0);
    beat(8'd50, 1'b0);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    in_last  = 1'b1;
    step();
    clr      = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("t5_clr_no_emit", 32'(a_out_valid), 32'd0);
    beat(8'd1, 1'b0);
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b0);
    beat(8'd4, 1'b0);
    check("t5_data", 32'(a_out_data), 32'd10);
    check("t5_beats", 32'(a_out_beats), 32'd4);
    step();
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    beat(8'd225, 1'b0);
    out_ready = 1'b0;
    clr       = 1'b1;
    step();
    step();
    clr = 1'b0;
    check("t5_full_clr_valid", 32'(a_out_valid), 32'd1);
    check("t5_full_clr_data", 32'(a_out_data), 32'd900);
    check("t5_full_clr_beats", 32'(a_out_beats), 32'd4);
    out_ready = 1'b1;
    step();
    check("t5_full_clr_retire", 32'(a_out_valid), 32'd0);

    // 6: COUNT=1 back to back, then reset with a pending result and a partial frame
    do_reset();
    beat(8'd3, 1'b0);
    check("t6_r0_valid", 32'(c_out_valid), 32'd1);
    check("t6_r0_data", 32'(c_out_data), 32'd3);
    check("t6_r0_beats", 32'(c_out_beats), 32'd1);
    beat(8'd5, 1'b0);
    check("t6_r1_valid", 32'(c_out_valid), 32'd1);
    check("t6_r1_data", 32'(c_out_data), 32'd5);
    beat(8'd9, 1'b0);
    check("t6_r2_data", 32'(c_out_data), 32'd9);
    out_ready = 1'b0;
    step();
    check("t6_pending_data", 32'(c_out_data), 32'd9);
    check("t6_pending_ready", 32'(c_in_ready), 32'd0);
    rst = 1'b1;
    step();
    check("t6_rst_valid", 32'(c_out_valid), 32'd0);
    check("t6_rst_data", 32'(c_out_data), 32'd0);
    check("t6_rst_beats", 32'(c_out_beats), 32'd0);
    check("t6_rst_ovf", 32'(c_out_ovf), 32'd0);
    check("t6_rst_ready", 32'(c_in_ready), 32'd1);
    check("t6_rst_main_ready", 32'(a_in_ready), 32'd1);
    rst       = 1'b0;
    out_ready = 1'b1;
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    beat(8'd1, 1'b0);
    check("t6_post_rst_data", 32'(a_out_data), 32'd4);
    check("t6_post_rst_beats", 32'(a_out_beats), 32'd4);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
